// File: rtl/fir_pkg.sv
// Shared types and limits for the FIR controller: FSM states, job command
// layout and the coefficient/sample count bounds.
package fir_pkg;

    localparam int unsigned WSP_AW_DEF = 5;
    localparam int unsigned PRB_AW_DEF = 13;
    localparam int unsigned DW_DEF     = 16;

    localparam int unsigned MAX_WSP = 32;
    localparam int unsigned MAX_PRB = 8192;
    localparam int unsigned WSP_CW  = 6;
    localparam int unsigned PRB_CW  = 14;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StStart,
        StWaitBusy,
        StRun,
        StDone
    } state_t;

    typedef struct packed {
        logic [WSP_CW-1:0] ile_wsp;
        logic [PRB_CW-1:0] ile_probek;
    } cmd_t;

    function automatic logic cmd_ok(cmd_t c);
        return (c.ile_wsp != '0) && (32'(c.ile_wsp) <= MAX_WSP) &&
               (c.ile_probek != '0) && (32'(c.ile_probek) <= MAX_PRB);
    endfunction

endpackage

// File: rtl/fir_cmd_fifo.sv
// Two-entry command FIFO; a push and a pop in the same cycle are both honoured,
// including when the FIFO is full.
module fir_cmd_fifo #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    T           mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // When full, wr_ptr aliases rd_ptr; the popped entry is consumed this cycle.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/fir_ctrl.sv
// FIR job controller: queues host commands, sequences the FIR engine and
// hands RAM ownership between host (idle) and FIR (any active state).
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned WSP_AW    = WSP_AW_DEF,
    parameter int unsigned PRB_AW    = PRB_AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned START_TMO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_cmd_valid,
    output logic              h_cmd_ready,
    input  logic [WSP_CW-1:0] h_ile_wsp,
    input  logic [PRB_CW-1:0] h_ile_probek,
    input  logic              h_wr,
    output logic              h_wr_ready,
    input  logic              h_sel,
    input  logic [PRB_AW-1:0] h_adres,
    input  logic [DW-1:0]     h_data,
    input  logic              h_irq_clr,
    output logic              irq_done,
    output logic              err,
    output logic              busy,
    output logic [15:0]       jobs_done,
    output logic              f_start,
    output logic [WSP_CW-1:0] f_ile_wsp,
    output logic [PRB_CW-1:0] f_ile_probek,
    input  logic              f_pracuje,
    input  logic              f_done,
    input  logic [WSP_AW-1:0] f_adress_fir,
    input  logic [PRB_AW-1:0] f_a_probki_fir,
    output logic              m_wsp_wr,
    output logic [WSP_AW-1:0] m_wsp_adres,
    output logic              m_prb_wr,
    output logic [PRB_AW-1:0] m_prb_adres,
    output logic [DW-1:0]     m_data
);

    localparam int unsigned TW = $clog2(START_TMO + 1);

    state_t        state_q, state_d;
    cmd_t          job_q, fifo_rdata, cmd_in;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          irq_q;
    logic [15:0]   jobs_q;
    logic          host_own;

    assign cmd_in      = '{ile_wsp: h_ile_wsp, ile_probek: h_ile_probek};
    assign fifo_pop    = (state_q == StIdle) && !fifo_empty;
    // A full FIFO still accepts when the idle FSM drains an entry this cycle.
    assign h_cmd_ready = !fifo_full || fifo_pop;
    assign fifo_push   = h_cmd_valid && h_cmd_ready;

    fir_cmd_fifo #(
        .T(cmd_t)
    ) u_cmd_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .wdata(cmd_in),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) state_d = StCheck;
            end
            StCheck: begin
                if (cmd_ok(job_q)) begin
                    state_d = StStart;
                end else begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StStart: begin
                state_d = StWaitBusy;
                tmo_d   = TW'(1);
            end
            // tmo_q counts cycles since f_start; err lands START_TMO cycles after it.
            StWaitBusy: begin
                if (f_done) begin
                    state_d = StDone;
                end else if (f_pracuje) begin
                    state_d = StRun;
                end else if (tmo_q == TW'(START_TMO - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StRun: begin
                if (f_done) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            job_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            if (fifo_pop) job_q <= fifo_rdata;
            irq_q <= (state_q == StDone) || (irq_q && !h_irq_clr);
            if (state_q == StDone) jobs_q <= jobs_q + 16'd1;
        end
    end

    assign f_start      = (state_q == StStart);
    assign f_ile_wsp    = job_q.ile_wsp;
    assign f_ile_probek = job_q.ile_probek;
    assign busy         = (state_q != StIdle);
    assign irq_done     = irq_q;
    assign err          = err_q;
    assign jobs_done    = jobs_q;

    // Ownership follows the state register directly, so it switches with no lag.
    assign host_own    = (state_q == StIdle);
    assign h_wr_ready  = host_own;
    assign m_wsp_wr    = host_own && h_wr && !h_sel;
    assign m_prb_wr    = host_own && h_wr && h_sel;
    assign m_wsp_adres = host_own ? h_adres[WSP_AW-1:0] : f_adress_fir;
    assign m_prb_adres = host_own ? h_adres : f_a_probki_fir;
    assign m_data      = h_data;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: expected DUT events are queued by the stimulus
// and consumed by a negedge monitor; a small FIR model answers f_start.
module tb_fir_ctrl;

    localparam int unsigned WSP_AW    = 5;
    localparam int unsigned PRB_AW    = 13;
    localparam int unsigned DW        = 16;
    localparam int unsigned START_TMO = 8;
    localparam logic [WSP_AW-1:0] F_WSP_ADR = 5'h15;
    localparam logic [PRB_AW-1:0] F_PRB_ADR = 13'h1ABC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              h_cmd_valid, h_cmd_ready;
    logic [5:0]        h_ile_wsp;
    logic [13:0]       h_ile_probek;
    logic              h_wr, h_wr_ready, h_sel;
    logic [PRB_AW-1:0] h_adres;
    logic [DW-1:0]     h_data;
    logic              h_irq_clr, irq_done, err, busy;
    logic [15:0]       jobs_done;
    logic              f_start;
    logic [5:0]        f_ile_wsp;
    logic [13:0]       f_ile_probek;
    logic              f_pracuje, f_done;
    logic [WSP_AW-1:0] f_adress_fir;
    logic [PRB_AW-1:0] f_a_probki_fir;
    logic              m_wsp_wr, m_prb_wr;
    logic [WSP_AW-1:0] m_wsp_adres;
    logic [PRB_AW-1:0] m_prb_adres;
    logic [DW-1:0]     m_data;

    fir_ctrl #(
        .WSP_AW   (WSP_AW),
        .PRB_AW   (PRB_AW),
        .DW       (DW),
        .START_TMO(START_TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_cmd_valid   (h_cmd_valid),
        .h_cmd_ready   (h_cmd_ready),
        .h_ile_wsp     (h_ile_wsp),
        .h_ile_probek  (h_ile_probek),
        .h_wr          (h_wr),
        .h_wr_ready    (h_wr_ready),
        .h_sel         (h_sel),
        .h_adres       (h_adres),
        .h_data        (h_data),
        .h_irq_clr     (h_irq_clr),
        .irq_done      (irq_done),
        .err           (err),
        .busy          (busy),
        .jobs_done     (jobs_done),
        .f_start       (f_start),
        .f_ile_wsp     (f_ile_wsp),
        .f_ile_probek  (f_ile_probek),
        .f_pracuje     (f_pracuje),
        .f_done        (f_done),
        .f_adress_fir  (f_adress_fir),
        .f_a_probki_fir(f_a_probki_fir),
        .m_wsp_wr      (m_wsp_wr),
        .m_wsp_adres   (m_wsp_adres),
        .m_prb_wr      (m_prb_wr),
        .m_prb_adres   (m_prb_adres),
        .m_data        (m_data)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EvStart, EvDone, EvErr, EvWr} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    ev_t         exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_start_cyc = 0;
    int          last_err_cyc = -1;
    int          last_done_cyc = -1;
    int          last_wr_cyc = -2;
    int          tmo_gap = 0;
    logic [15:0] prev_jobs = 16'd0;
    logic        fir_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void expect_ev(ev_kind_t k, logic [15:0] ka, logic [15:0] kb);
        ev_t e;
        e.kind = k;
        e.a    = ka;
        e.b    = kb;
        exp_q.push_back(e);
    endfunction

    task automatic sb_take(input ev_kind_t k, input logic [15:0] ka, input logic [15:0] kb);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got %s a=0x%0h b=0x%0h, expected no event",
                     k.name(), ka, kb);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != ka || (k != EvErr && e.b != kb)) begin
                n_bad++;
                $display("FAIL sb_event: got %s a=0x%0h b=0x%0h, expected %s a=0x%0h b=0x%0h",
                         k.name(), ka, kb, e.kind.name(), e.a, e.b);
            end
        end
    endtask

    // Monitor: every observable DUT event is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_jobs = jobs_done;
        end else begin
            if (f_start) begin
                last_start_cyc = cyc;
                sb_take(EvStart, {10'd0, f_ile_wsp}, {2'd0, f_ile_probek});
            end
            if (jobs_done != prev_jobs) begin
                last_done_cyc = cyc;
                prev_jobs     = jobs_done;
                sb_take(EvDone, jobs_done, {15'd0, irq_done});
            end
            if (err) begin
                last_err_cyc = cyc;
                tmo_gap      = cyc - last_start_cyc;
                sb_take(EvErr, jobs_done, 16'd0);
            end
            if (m_wsp_wr || m_prb_wr) begin
                last_wr_cyc = cyc;
                sb_take(EvWr, m_prb_wr ? {3'b100, m_prb_adres} : {11'd0, m_wsp_adres}, m_data);
            end
        end
    end

    // FIR engine model; a job with 7 coefficients never answers.
    initial begin
        f_pracuje = 1'b0;
        f_done    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && f_start && f_ile_wsp != 6'd7) begin
                f_pracuje = 1'b1;
                repeat (3) @(negedge clk);
                while (fir_hold && rst_n) @(negedge clk);
                if (rst_n) begin
                    f_done = 1'b1;
                    @(negedge clk);
                    f_done = 1'b0;
                end
                f_pracuje = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [5:0] w, input logic [13:0] p, output int acc_cyc);
        int n = 0;
        h_cmd_valid  = 1'b1;
        h_ile_wsp    = w;
        h_ile_probek = p;
        while (!h_cmd_ready && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL cmd_ready_timeout: got ready=0 for %0d cycles, expected 1", n);
        end
        acc_cyc = cyc;
        step(1);
        h_cmd_valid = 1'b0;
    endtask

    task automatic host_write(input logic sel, input logic [PRB_AW-1:0] adr,
                              input logic [DW-1:0] d, output int stalls);
        expect_ev(EvWr, sel ? (16'h8000 | {3'b000, adr}) : {11'd0, adr[WSP_AW-1:0]}, d);
        h_wr    = 1'b1;
        h_sel   = sel;
        h_adres = adr;
        h_data  = d;
        stalls  = 0;
        while (!h_wr_ready && stalls < 200) begin
            step(1);
            stalls++;
        end
        if (stalls >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL wr_ready_timeout: got ready=0 for %0d cycles, expected 1", stalls);
        end
        step(1);
        h_wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            step(1);
            n++;
        end
        if (n >= 400) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_drain: got %0d events pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(busy && f_pracuje) && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_timeout: got f_pracuje=0, expected 1");
        end
        step(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_f_start"},   32'(f_start), 32'd0);
        chk({tag, "_f_wsp"},     32'(f_ile_wsp), 32'd0);
        chk({tag, "_f_prb"},     32'(f_ile_probek), 32'd0);
        chk({tag, "_irq"},       32'(irq_done), 32'd0);
        chk({tag, "_err"},       32'(err), 32'd0);
        chk({tag, "_jobs"},      32'(jobs_done), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(h_cmd_ready), 32'd1);
        chk({tag, "_wr_ready"},  32'(h_wr_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, expected finish");
        $fatal(1);
    end

    initial begin
        int acc, acc_d, stl, n;
        rst_n          = 1'b0;
        h_cmd_valid    = 1'b0;
        h_ile_wsp      = '0;
        h_ile_probek   = '0;
        h_wr           = 1'b0;
        h_sel          = 1'b0;
        h_adres        = '0;
        h_data         = '0;
        h_irq_clr      = 1'b0;
        f_adress_fir   = F_WSP_ADR;
        f_a_probki_fir = F_PRB_ADR;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        step(1);
        rst_n = 1'b1;
        chk("rel_cmd_ready", 32'(h_cmd_ready), 32'd1);
        chk("rel_wr_ready", 32'(h_wr_ready), 32'd1);

        // Load coefficients and samples, then one normal job.
        host_write(1'b0, 13'd0, 16'hC000, stl);
        host_write(1'b0, 13'd1, 16'h4000, stl);
        host_write(1'b0, 13'd2, 16'hC000, stl);
        for (int i = 0; i < 4; i++) host_write(1'b1, 13'(i), 16'h2000, stl);
        expect_ev(EvStart, 16'd3, 16'd3);
        expect_ev(EvDone, 16'd1, 16'd1);
        send_cmd(6'd3, 14'd3, acc);
        wait_drain("job1");
        chk("job1_jobs", 32'(jobs_done), 32'd1);
        chk("job1_irq", 32'(irq_done), 32'd1);
        chk("job1_f_wsp", 32'(f_ile_wsp), 32'd3);
        chk("job1_f_prb", 32'(f_ile_probek), 32'd3);
        h_irq_clr = 1'b1;
        step(1);
        h_irq_clr = 1'b0;
        chk("irq_clr", 32'(irq_done), 32'd0);

        // Invalid counts are rejected with an err pulse each.
        expect_ev(EvErr, 16'd1, 16'd0);
        expect_ev(EvErr, 16'd1, 16'd0);
        send_cmd(6'd0, 14'd3, acc);
        send_cmd(6'd3, 14'd0, acc);
        wait_drain("bad");
        chk("bad_jobs", 32'(jobs_done), 32'd1);

        // Host write during RUN stalls, then lands in the first idle cycle.
        fir_hold = 1'b1;
        expect_ev(EvStart, 16'd2, 16'd2);
        expect_ev(EvDone, 16'd2, 16'd1);
        send_cmd(6'd2, 14'd2, acc);
        wait_run();
        chk("run_wr_ready", 32'(h_wr_ready), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_wsp_adr", 32'(m_wsp_adres), 32'(F_WSP_ADR));
        chk("run_prb_adr", 32'(m_prb_adres), 32'(F_PRB_ADR));
        fork
            host_write(1'b0, 13'd7, 16'hABCD, stl);
            begin
                step(4);
                fir_hold = 1'b0;
            end
        join
        wait_drain("wr_run");
        chk("wr_stalled", 32'(stl > 0), 32'd1);
        chk("wr_first_idle", 32'(last_wr_cyc), 32'(last_done_cyc));

        // Clear coinciding with DONE: set wins.
        h_irq_clr = 1'b1;
        step(1);
        h_irq_clr = 1'b0;
        chk("irq_clr2", 32'(irq_done), 32'd0);
        fir_hold = 1'b1;
        expect_ev(EvStart, 16'd1, 16'd1);
        expect_ev(EvDone, 16'd3, 16'd1);
        send_cmd(6'd1, 14'd1, acc);
        wait_run();
        fir_hold = 1'b0;
        n = 0;
        while (!f_done && n < 50) begin
            step(1);
            n++;
        end
        h_irq_clr = 1'b1;
        chk("done_busy", 32'(busy), 32'd1);
        step(1);
        h_irq_clr = 1'b0;
        chk("irq_set_wins", 32'(irq_done), 32'd1);
        wait_drain("irqclr");

        // Reset mid-RUN abandons the job.
        fir_hold = 1'b1;
        expect_ev(EvStart, 16'd3, 16'd3);
        send_cmd(6'd3, 14'd3, acc);
        wait_run();
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        fir_hold = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("midrst_jobs_after", 32'(jobs_done), 32'd0);
        chk("midrst_irq_after", 32'(irq_done), 32'd0);

        // Dead FIR job times out while three commands queue behind it.
        expect_ev(EvStart, 16'd7, 16'd5);
        expect_ev(EvErr, 16'd0, 16'd0);
        expect_ev(EvStart, 16'd4, 16'd10);
        expect_ev(EvDone, 16'd1, 16'd1);
        expect_ev(EvStart, 16'd5, 16'd20);
        expect_ev(EvDone, 16'd2, 16'd1);
        expect_ev(EvStart, 16'd6, 16'd30);
        expect_ev(EvDone, 16'd3, 16'd1);
        send_cmd(6'd7, 14'd5, acc);
        send_cmd(6'd4, 14'd10, acc);
        send_cmd(6'd5, 14'd20, acc);
        chk("fifo_full_ready", 32'(h_cmd_ready), 32'd0);
        send_cmd(6'd6, 14'd30, acc_d);
        wait_drain("queue3");
        chk("tmo_gap", 32'(tmo_gap), 32'(START_TMO));
        chk("third_accept_at_pop", 32'(acc_d), 32'(last_err_cyc));
        chk("queue3_jobs", 32'(jobs_done), 32'd3);

        step(5);
        chk("leftover_events", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
